tinyalu_requester: RTL and testbench

//  Initiator side of the TinyALU start/done protocol.
//  - Accepts commands (op, A, B) on a valid/ready port and buffers them in a small FIFO.
//  - Drives them one at a time into tinyalu via alu_start/alu_op/alu_a/alu_b.
//  - Waits for alu_done, captures alu_result, returns it on a valid/ready response port.
//  - Sits between the testbench/CPU-side command source and tinyalu.

---
 rtl/tinyalu_pkg.sv | 33 +++
 rtl/tinyalu_cmd_fifo.sv | 44 ++++
 rtl/tinyalu_requester.sv | 118 +++++++++++
 tb/tb_tinyalu_requester.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tinyalu_pkg.sv
// Shared types for the TinyALU requester: ALU opcodes, FSM states and the buffered command.
package tinyalu_pkg;

  typedef enum logic [2:0] {
    no_op  = 3'b000,
    add_op = 3'b001,
    and_op = 3'b010,
    xor_op = 3'b011,
    mul_op = 3'b100
  } operation_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } alu_cmd_t;

  // Ops that actually start tinyalu and produce a done pulse.
  function automatic logic op_needs_alu(logic [2:0] op);
    return (op >= 3'(add_op)) && (op <= 3'(mul_op));
  endfunction

  function automatic logic op_is_illegal(logic [2:0] op);
    return op > 3'(mul_op);
  endfunction

endpackage

// File: rtl/tinyalu_cmd_fifo.sv
// Small command FIFO. Extra pointer bit distinguishes full from empty; no read bypass.
module tinyalu_cmd_fifo
  import tinyalu_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic     clk_i,
  input  logic     reset_i,
  input  logic     push_i,
  input  alu_cmd_t wdata_i,
  input  logic     pop_i,
  output alu_cmd_t rdata_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  alu_cmd_t         mem_q [Depth];
  logic [AddrW:0]   wptr_q, rptr_q;
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                   (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rptr_q[AddrW-1:0]];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AddrW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/tinyalu_requester.sv
// Initiator for the TinyALU start/done protocol: queues commands, issues them one at a time,
// and returns each result (or an error for illegal ops / timeouts) on a valid/ready port.
module tinyalu_requester
  import tinyalu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [2:0]  rsp_op,
  output logic        rsp_err,
  output logic        alu_start,
  output logic [2:0]  alu_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  output logic        busy
);

  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  state_t          state_q;
  logic [TmoW-1:0] tmo_q;
  alu_cmd_t        fifo_wdata, fifo_head;
  logic            fifo_full, fifo_empty, fifo_pop;

  assign fifo_wdata = '{op: cmd_op, a: cmd_a, b: cmd_b};
  assign fifo_pop   = (state_q == IDLE) && !fifo_empty;
  assign cmd_ready  = !fifo_full;
  assign busy       = (state_q != IDLE) || !fifo_empty;

  tinyalu_cmd_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (cmd_valid),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tmo_q      <= '0;
      alu_start  <= 1'b0;
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_op     <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            alu_op <= fifo_head.op;
            alu_a  <= fifo_head.a;
            alu_b  <= fifo_head.b;
            tmo_q  <= '0;
            if (op_needs_alu(fifo_head.op)) begin
              state_q   <= ISSUE;
              alu_start <= 1'b1;
            end else begin
              // no_op and illegal ops never touch tinyalu
              state_q    <= RESP;
              rsp_valid  <= 1'b1;
              rsp_result <= '0;
              rsp_op     <= fifo_head.op;
              rsp_err    <= op_is_illegal(fifo_head.op);
            end
          end
        end
        ISSUE: begin
          if (alu_done) begin
            state_q    <= RESP;
            alu_start  <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_result <= alu_result;
            rsp_op     <= alu_op;
            rsp_err    <= 1'b0;
          end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
            state_q    <= RESP;
            alu_start  <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_result <= '0;
            rsp_op     <= alu_op;
            rsp_err    <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q   <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tinyalu_requester.sv
// Bench for tinyalu_requester paired with a small behavioural TinyALU model.
module tb_tinyalu_requester;
  import tinyalu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_a, cmd_b;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_result;
  logic [2:0]  rsp_op;
  logic        rsp_err;
  logic        alu_start;
  logic [2:0]  alu_op;
  logic [7:0]  alu_a, alu_b;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        busy;

  always #5 clk = ~clk;

  tinyalu_requester #(
    .FIFO_DEPTH (4),
    .TIMEOUT    (15)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_op     (rsp_op),
    .rsp_err    (rsp_err),
    .alu_start  (alu_start),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_done   (alu_done),
    .alu_result (alu_result),
    .busy       (busy)
  );

  // TinyALU model: single-cycle ops done the cycle after start is sampled,
  // mul done 4 cycles after start is sampled; one idle cycle after each done.
  logic        m_done;
  logic [1:0]  m_cnt;
  logic [15:0] m_result;
  logic        kill_done;

  assign alu_done   = m_done & ~kill_done;
  assign alu_result = m_result;

  always @(posedge clk) begin
    if (reset) begin
      m_done   <= 1'b0;
      m_cnt    <= 2'd0;
      m_result <= 16'h0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_cnt != 2'd0) begin
      m_cnt <= m_cnt - 2'd1;
      if (m_cnt == 2'd1) m_done <= 1'b1;
    end else if (alu_start && alu_op != 3'b000) begin
      case (alu_op)
        3'b001:  begin m_result <= {8'h00, alu_a} + {8'h00, alu_b}; m_done <= 1'b1; end
        3'b010:  begin m_result <= {8'h00, alu_a & alu_b}; m_done <= 1'b1; end
        3'b011:  begin m_result <= {8'h00, alu_a ^ alu_b}; m_done <= 1'b1; end
        default: begin m_result <= {8'h00, alu_a} * {8'h00, alu_b}; m_cnt <= 2'd3; end
      endcase
    end
  end

  typedef struct {
    logic [2:0]  op;
    logic [15:0] res;
    logic        err;
  } rsp_t;

  rsp_t rsp_q[$];
  int   start_cnt = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (rsp_valid && rsp_ready) rsp_q.push_back('{rsp_op, rsp_result, rsp_err});
      if (alu_start) start_cnt <= start_cnt + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic acc;
    int   guard;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    guard     = 0;
    acc       = 1'b0;
    while (!acc && guard < 100) begin
      @(negedge clk);
      acc = cmd_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    cmd_valid = 1'b0;
    if (!acc) check("send_accept", 0, 1);
  endtask

  task automatic wait_rsps(input int n, input string name);
    int guard = 0;
    while (rsp_q.size() < n && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check(name, rsp_q.size(), n);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    logic        err;
  } vec_t;

  vec_t        vecs[8];
  logic [12:0] sp, vp;
  logic [15:0] r;
  logic        e;
  int          base;

  initial begin
    vecs[0] = '{3'd1, 8'h12, 8'h34, 16'h0046, 1'b0};
    vecs[1] = '{3'd2, 8'hF0, 8'h3C, 16'h0030, 1'b0};
    vecs[2] = '{3'd3, 8'hF0, 8'h3C, 16'h00CC, 1'b0};
    vecs[3] = '{3'd4, 8'h10, 8'h10, 16'h0100, 1'b0};
    vecs[4] = '{3'd4, 8'hFF, 8'hFF, 16'hFE01, 1'b0};
    vecs[5] = '{3'd1, 8'hFF, 8'hFF, 16'h01FE, 1'b0};
    vecs[6] = '{3'd0, 8'h55, 8'h66, 16'h0000, 1'b0};
    vecs[7] = '{3'd5, 8'h01, 8'h02, 16'h0000, 1'b1};

    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_a     = 8'h0;
    cmd_b     = 8'h0;
    rsp_ready = 1'b1;
    kill_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_alu_start", alu_start, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_rsp_err", rsp_err, 0);
    @(posedge clk);
    #1;

    // Single add: start in cycles 2-3, response in cycle 4.
    rsp_q.delete();
    sp = '0; vp = '0; r = '0; e = 1'b1;
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_a = 8'hFF; cmd_b = 8'h01;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      sp[c] = alu_start;
      vp[c] = rsp_valid;
      if (rsp_valid) begin r = rsp_result; e = rsp_err; end
      @(posedge clk);
      #1 cmd_valid = 1'b0;
    end
    check("add_start_pattern", {26'h0, sp[5:0]}, 32'b001100);
    check("add_valid_pattern", {26'h0, vp[5:0]}, 32'b010000);
    check("add_result", r, 16'h0100);
    check("add_err", e, 0);

    // mul then add: mul start in cycles 2-6, gap of 2 low cycles, add start 9-10.
    rsp_q.delete();
    sp = '0; vp = '0;
    cmd_valid = 1'b1; cmd_op = 3'd4; cmd_a = 8'hFF; cmd_b = 8'hFF;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      sp[c] = alu_start;
      vp[c] = rsp_valid;
      @(posedge clk);
      #1;
      if (c == 0) begin cmd_op = 3'd1; cmd_a = 8'h01; cmd_b = 8'h02; end
      else cmd_valid = 1'b0;
    end
    check("mul_start_pattern", {19'h0, sp}, 32'h067C);
    check("mul_valid_pattern", {19'h0, vp}, 32'h0880);
    wait_rsps(2, "mul_rsp_count");
    if (rsp_q.size() >= 2) begin
      check("mul_result", rsp_q[0].res, 16'hFE01);
      check("mul_err", rsp_q[0].err, 0);
      check("mul_next_result", rsp_q[1].res, 16'h0003);
    end

    // Table of single commands with rsp_ready held high.
    for (int i = 0; i < 8; i++) begin
      rsp_q.delete();
      send(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_rsps(1, $sformatf("vec%0d_count", i));
      if (rsp_q.size() >= 1) begin
        check($sformatf("vec%0d_result", i), rsp_q[0].res, vecs[i].res);
        check($sformatf("vec%0d_err", i), rsp_q[0].err, vecs[i].err);
        check($sformatf("vec%0d_op", i), rsp_q[0].op, vecs[i].op);
      end
    end

    // Back-pressure: 5 commands fill the FIFO behind the stalled response.
    rsp_q.delete();
    rsp_ready = 1'b0;
    send(3'd2, 8'hF0, 8'h3C);
    send(3'd3, 8'h55, 8'h0F);
    send(3'd1, 8'h80, 8'h80);
    send(3'd4, 8'h0C, 8'h0B);
    send(3'd1, 8'h01, 8'h02);
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_a = 8'h77; cmd_b = 8'h11;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("full_cmd_ready", cmd_ready, 0);
      check("full_rsp_held", rsp_result, 16'h0030);
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    check("full_busy", busy, 1);
    rsp_ready = 1'b1;
    wait_rsps(5, "bp_rsp_count");
    if (rsp_q.size() >= 5) begin
      check("bp_and", rsp_q[0].res, 16'h0030);
      check("bp_xor", rsp_q[1].res, 16'h005A);
      check("bp_add", rsp_q[2].res, 16'h0100);
      check("bp_mul", rsp_q[3].res, 16'h0084);
      check("bp_add2", rsp_q[4].res, 16'h0003);
    end
    repeat (5) @(posedge clk);
    #1;
    check("bp_no_extra", rsp_q.size(), 5);

    // no_op and an illegal op never raise alu_start.
    rsp_q.delete();
    base = start_cnt;
    send(3'd0, 8'h12, 8'h34);
    send(3'd6, 8'h12, 8'h34);
    wait_rsps(2, "noalu_rsp_count");
    check("noalu_no_start", start_cnt - base, 0);
    if (rsp_q.size() >= 2) begin
      check("noop_result", rsp_q[0].res, 0);
      check("noop_err", rsp_q[0].err, 0);
      check("illegal_result", rsp_q[1].res, 0);
      check("illegal_err", rsp_q[1].err, 1);
      check("illegal_op", rsp_q[1].op, 3'd6);
    end

    // Timeout: done suppressed, ISSUE lasts exactly TIMEOUT cycles.
    rsp_q.delete();
    kill_done = 1'b1;
    base = start_cnt;
    send(3'd1, 8'h03, 8'h04);
    wait_rsps(1, "tmo_rsp_count");
    check("tmo_issue_cycles", start_cnt - base, 15);
    if (rsp_q.size() >= 1) begin
      check("tmo_err", rsp_q[0].err, 1);
      check("tmo_result", rsp_q[0].res, 0);
    end
    @(negedge clk);
    check("tmo_idle", busy, 0);
    repeat (3) @(posedge clk);
    #1 kill_done = 1'b0;

    // Reset while in ISSUE with two commands queued.
    rsp_q.delete();
    send(3'd4, 8'h02, 8'h03);
    send(3'd1, 8'h01, 8'h01);
    send(3'd1, 8'h02, 8'h02);
    @(negedge clk);
    check("prerst_alu_start", alu_start, 1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("mrst_alu_start", alu_start, 0);
    check("mrst_rsp_valid", rsp_valid, 0);
    check("mrst_cmd_ready", cmd_ready, 1);
    check("mrst_busy", busy, 0);
    base = start_cnt;
    repeat (20) @(posedge clk);
    #1;
    check("mrst_no_rsp", rsp_q.size(), 0);
    check("mrst_no_start", start_cnt - base, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
